// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and default widths for the SCLK arbiter.
//   state_t   : IDLE, LOAD, RUN, GAP (GAP is only entered when SCLK_ARB_GAP_EN is defined)
//   DEF_DIV_W : default divide-value width
//   DEF_CNT_W : default burst-length width
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;
    localparam int DEF_DIV_W = 16;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/sclk_gen.sv
// sclk_gen: loadable half-period counter driving sclk with registered edge strobes.
//   clk, rst   : system clock, synchronous active-high reset
//   load_i     : latch div_i, clear phase, force sclk low (fall_stb if it was high)
//   run_i      : advance the phase counter; toggle sclk when phase equals latched div
//   div_i      : half-period minus one
//   sclk_o     : serial clock, idles low
//   rise_stb_o : high in the first cycle sclk_o is high
//   fall_stb_o : high in the first cycle sclk_o is low after a high phase
module sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sclk_o,
    output logic             rise_stb_o,
    output logic             fall_stb_o
);
    logic [DIV_W-1:0] div_q, div_d, ph_q, ph_d;
    logic sclk_q, sclk_d, rise_q, rise_d, fall_q, fall_d, tick;

    always_comb begin
        tick   = run_i && (ph_q == div_q);
        div_d  = load_i ? div_i : div_q;
        ph_d   = (load_i || tick) ? '0 : run_i ? ph_q + DIV_W'(1) : ph_q;
        sclk_d = load_i ? 1'b0 : tick ? ~sclk_q : sclk_q;
        rise_d = !load_i && tick && !sclk_q;
        // a forced stop (load) still reports the falling edge if sclk was high
        fall_d = load_i ? sclk_q : tick && sclk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            ph_q   <= '0;
            sclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            ph_q   <= ph_d;
            sclk_q <= sclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign rise_stb_o = rise_q;
    assign fall_stb_o = fall_q;
endmodule

// File: rtl/sclk_arbiter.sv
// sclk_arbiter: round-robin sharing of one SCLK generator among NREQ SPI requesters.
//   clk, rst : system clock, synchronous active-high reset
//   req      : per-requester request level
//   div      : per-requester half-period minus one, slice i = [i*DIV_W +: DIV_W]
//   nbits    : per-requester burst length in full SCLK periods
//   grant    : one-hot generator owner
//   sclk     : serial clock, idles low; rise_stb/fall_stb mark its edges
//   done     : one-cycle one-hot pulse on normal completion
//   busy     : any grant active
// Optional: define SCLK_ARB_GAP_EN to insert GAP_CYCLES idle cycles after every release.
module sclk_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DIV_W-1:0] div,
    input  logic [NREQ*CNT_W-1:0] nbits,
    output logic [NREQ-1:0]       grant,
    output logic                  sclk,
    output logic                  rise_stb,
    output logic                  fall_stb,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);
    localparam int PW = $clog2(NREQ);

    state_t state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d, pick;
    logic [CNT_W-1:0] nbits_q, nbits_d, cnt_q, cnt_d;
    logic found, complete, abort, rel;
    int idx;

`ifdef SCLK_ARB_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam state_t REL_ST = GAP;
    logic [GW-1:0] gap_q, gap_d;
`else
    localparam state_t REL_ST = IDLE;
    logic unused_gap;
    assign unused_gap = ^GAP_CYCLES;
`endif

    // first set request at or after the pointer, scanning cyclically
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    end

    // completion wins over a same-cycle request drop so done never depends on req
    always_comb begin
        complete = (state_q == RUN) &&
                   (nbits_q == '0 || (fall_stb && cnt_q == nbits_q - CNT_W'(1)));
        abort    = (state_q == LOAD || state_q == RUN) && !(|(req & grant_q)) && !complete;
        rel      = complete || abort;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        nbits_d = nbits_q;
        cnt_d   = cnt_q;
`ifdef SCLK_ARB_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: if (|req) begin
                win_d   = pick;
                grant_d = NREQ'(1) << pick;
                state_d = LOAD;
            end
            LOAD: begin
                nbits_d = nbits[win_q*CNT_W +: CNT_W];
                cnt_d   = '0;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                state_d = RUN;
            end
            RUN: cnt_d = fall_stb ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef SCLK_ARB_GAP_EN
            GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = (gap_q == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (rel) begin
            grant_d = '0;
            state_d = REL_ST;
`ifdef SCLK_ARB_GAP_EN
            gap_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            nbits_q <= '0;
            cnt_q   <= '0;
`ifdef SCLK_ARB_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            nbits_q <= nbits_d;
            cnt_q   <= cnt_d;
`ifdef SCLK_ARB_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // an abort reuses the generator load path to drop sclk and emit the fall strobe
    sclk_gen #(.DIV_W(DIV_W)) u_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == LOAD || abort),
        .run_i      (state_q == RUN && !rel),
        .div_i      (div[win_q*DIV_W +: DIV_W]),
        .sclk_o     (sclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    assign grant = grant_q;
    assign busy  = |grant_q;
    assign done  = complete ? grant_q : '0;
endmodule

// File: tb/tb_sclk_arbiter.sv
// tb_sclk_arbiter: directed self-checking bench for sclk_arbiter with NREQ=4.
module tb_sclk_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] div;
    logic [31:0] nbits;
    logic [3:0]  grant, done;
    logic        sclk, rise_stb, fall_stb, busy;
    int checks = 0;
    int errors = 0;
    int nr, nf, nd, r1, r2, dk, lf, bl, exp_bl;
    logic [3:0] dv, g18, dacc;

    sclk_arbiter #(.NREQ(4), .DIV_W(16), .CNT_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .div(div), .nbits(nbits),
        .grant(grant), .sclk(sclk), .rise_stb(rise_stb), .fall_stb(fall_stb),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; div = '0; nbits = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_rise", 32'(rise_stb), 0);
        chk("rst_fall", 32'(fall_stb), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // single request: div=3, nbits=2
        div[0 +: 16] = 16'd3; nbits[0 +: 8] = 8'd2; req = 4'b0001;
        @(negedge clk);
        chk("single_grant_L", 32'(grant), 32'h1);
        chk("single_busy_L", 32'(busy), 1);
        nr = 0; nf = 0; nd = 0; r1 = -1; r2 = -1; dk = -1; lf = -1; dv = '0; g18 = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rise_stb) begin nr++; if (r1 < 0) r1 = k; else r2 = k; end
            if (fall_stb) begin nf++; lf = k; end
            if (done != 0) begin nd++; dk = k; dv = done; req = '0; end
            if (k == 18) g18 = grant;
        end
        chk("single_rise1", 32'(r1), 5);
        chk("single_rise2", 32'(r2), 13);
        chk("single_nrise", 32'(nr), 2);
        chk("single_nfall", 32'(nf), 2);
        chk("single_lastfall", 32'(lf), 17);
        chk("single_ndone", 32'(nd), 1);
        chk("single_done_cyc", 32'(dk), 17);
        chk("single_done_val", 32'(dv), 32'h1);
        chk("single_grant_rel", 32'(g18), 0);

        // round-robin: all requesting, div=0, nbits=1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            div[i*16 +: 16] = 16'd0;
            nbits[i*8 +: 8] = 8'd1;
        end
        req = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            repeat (3) @(negedge clk);
            chk("rr_done", 32'(done), 32'(4'b0001 << (i % 4)));
            repeat (2) @(negedge clk);
        end
        req = '0;
        @(negedge clk);

        // abort: requester 2 drops req mid high phase
        do_reset();
        div[32 +: 16] = 16'd3; nbits[16 +: 8] = 8'd4; req = 4'b0100;
        @(negedge clk);
        chk("abort_grant_L", 32'(grant), 32'h4);
        dacc = '0;
        repeat (6) begin @(negedge clk); dacc = dacc | done; end
        chk("abort_sclk_hi", 32'(sclk), 1);
        req = '0;
        @(negedge clk);
        dacc = dacc | done;
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_fall", 32'(fall_stb), 1);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        dacc = dacc | done;
        chk("abort_fall_once", 32'(fall_stb), 0);
        chk("abort_nodone", 32'(dacc), 0);

        // nbits=0: done right after LOAD, no strobes
        div[0 +: 16] = 16'd0; nbits[0 +: 8] = 8'd0; req = 4'b0001;
        @(negedge clk);
        chk("nb0_grant_L", 32'(grant), 32'h1);
        nr = 0; nf = 0;
        @(negedge clk);
        chk("nb0_done", 32'(done), 32'h1);
        req = '0;
        repeat (4) begin
            if (rise_stb || sclk) nr++;
            if (fall_stb) nf++;
            @(negedge clk);
        end
        chk("nb0_nrise", 32'(nr), 0);
        chk("nb0_nfall", 32'(nf), 0);
        chk("nb0_grant_rel", 32'(grant), 0);

        // reset mid-burst on requester 2, then requesters 1 and 3 compete
        req = 4'b0100;
        @(negedge clk);
        chk("rmid_grant_L", 32'(grant), 32'h4);
        repeat (6) @(negedge clk);
        chk("rmid_sclk_hi", 32'(sclk), 1);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("rmid_grant", 32'(grant), 0);
        chk("rmid_sclk", 32'(sclk), 0);
        chk("rmid_rise", 32'(rise_stb), 0);
        chk("rmid_fall", 32'(fall_stb), 0);
        chk("rmid_done", 32'(done), 0);
        chk("rmid_busy", 32'(busy), 0);
        rst = 1'b0; req = 4'b1010;
        @(negedge clk);
        chk("rmid_ptr0_grant", 32'(grant), 32'h2);
        req = '0;
        repeat (5) @(negedge clk);

        // back-to-back bursts: busy-low spacing between release and next LOAD
        div[0 +: 16] = 16'd0; nbits[0 +: 8] = 8'd1;
        div[16 +: 16] = 16'd0; nbits[8 +: 8] = 8'd1;
        req = 4'b0011;
        @(negedge clk);
        chk("gap_grant0", 32'(grant), 32'h1);
        repeat (3) @(negedge clk);
        chk("gap_done0", 32'(done), 32'h1);
        req = 4'b0010;
`ifdef SCLK_ARB_GAP_EN
        exp_bl = 3;
`else
        exp_bl = 1;
`endif
        bl = 0;
        @(negedge clk);
        while (!busy && bl < 10) begin
            bl++;
            @(negedge clk);
        end
        chk("gap_busy_low", 32'(bl), 32'(exp_bl));
        chk("gap_grant1", 32'(grant), 32'h2);
        req = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sclk_arbiter.md
# sclk_arbiter

Shares one programmable serial-clock generator among `NREQ` requesters in the SPI subsystem. Each requester asks for a burst of a given number of SCLK periods at its own divide ratio. The block grants the generator round-robin, produces the burst with edge strobes, and signals completion to the granted requester. It sits between the per-channel SPI shift engines and the single physical SCLK pin.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DIV_W`, 16: width of the divide value.
- `CNT_W`, 8: width of the burst-length field.
- `GAP_CYCLES`, 2: idle clk cycles between grants. Used only with the gap feature.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `req` in `NREQ`: per-requester request level.
- `div` in `NREQ*DIV_W`: per-requester half-period minus one; slice i = `[i*DIV_W +: DIV_W]`.
- `nbits` in `NREQ*CNT_W`: per-requester burst length in full SCLK periods.
- `grant` out `NREQ`: one-hot owner of the generator.
- `sclk` out 1: generated serial clock; idles low.
- `rise_stb` out 1: one-cycle pulse, high in the first cycle `sclk` is high.
- `fall_stb` out 1: one-cycle pulse, high in the first cycle `sclk` is low after a high phase.
- `done` out `NREQ`: one-cycle one-hot pulse on normal burst completion.
- `busy` out 1: high while any grant is active.

## Operation
- Reset values: `grant`=0, `sclk`=0, `rise_stb`=0, `fall_stb`=0, `done`=0, `busy`=0. The round-robin pointer resets to 0, state to IDLE, and all counters to 0.
- States: IDLE, LOAD, RUN, and GAP (GAP exists only with the feature enabled).
- IDLE: if any `req` bit is high, select the first set bit at or after the pointer, cyclically. Then set `grant`, go to LOAD.
- LOAD (1 cycle): latch the `div` and `nbits` slices of the winner. Clear the phase counter and the edge counter. The pointer becomes winner+1 mod `NREQ`. Go to RUN.
- RUN: the phase counter increments every clk. When it equals the latched div, it wraps to 0 and `sclk` toggles, so each half-period is div+1 clk cycles.
  - Each high-to-low toggle increments the edge counter.
  - When the edge counter reaches the latched nbits: pulse `done[winner]`, clear `grant`, go to GAP or IDLE.
- Latched nbits = 0: go directly from LOAD to completion. No `sclk` activity, `done` pulses in the cycle after LOAD.
- div = 0: `sclk` toggles every clk.
- Abort: if the granted `req` bit falls during LOAD or RUN, the next cycle forces `sclk` to 0, clears `grant`, and goes to GAP or IDLE.
  - No `done` pulse. `fall_stb` pulses only if `sclk` was high.
- Requests from non-granted requesters are ignored until the current owner releases.
- Inputs for the winner are sampled only in LOAD. Changes during RUN have no effect.
- Counter widths: the phase counter is `DIV_W` bits; the edge counter is `CNT_W` bits. There is no overflow path because the compare happens before the increment.

## Timing
- `req` rises in cycle t while IDLE → `grant` and `busy` are high from t+1 (LOAD cycle L = t+1).
- First `rise_stb`/`sclk` high at L+2+div.
- Final `fall_stb` at L+1+2·nbits·(div+1). `done` pulses in that same cycle.
- `grant`/`busy` low from the cycle after the final `fall_stb`.
- The next grant is possible in the IDLE cycle after release, so the next LOAD comes 2 cycles after release. With the gap feature, add `GAP_CYCLES`.
- `rst` asserted mid-burst: all outputs take their reset values on the next edge. No `done` pulse.

## Configuration
- `SCLK_ARB_GAP_EN` defined: after every release (done or abort), the block holds GAP for exactly `GAP_CYCLES` cycles with `sclk`=0 and `busy`=0, then returns to IDLE. This guarantees chip-select deassert time.
- Not defined: the block returns directly to IDLE and the GAP state is not synthesized.

## Structure
- Shared package `spi_pkg`: state encoding (IDLE, LOAD, RUN, GAP) and the default widths `DIV_W`/`CNT_W`.
- One sub-module, `sclk_gen`:
  - contains the loadable phase counter, the `sclk` register, and the strobes;
  - takes `load`, `run`, and `div` inputs; produces `sclk`, `rise_stb`, `fall_stb`.
- The arbiter FSM, pointer, and edge counter live in the top level.

## Test plan
- Single request: `req`=0001, div=3, nbits=2. Required: `grant`=0001 at L; rises at L+5 and L+13; `done`=0001 at L+17; 2 `fall_stb` pulses total.
- Round-robin: `req`=1111 held, all nbits=1, div=0. Required: grant order 0,1,2,3,0; each `done` 3 cycles after its LOAD.
- Abort: requester 2 drops `req` mid high phase. Required: next cycle `sclk`=0, one `fall_stb`, `grant`=0, no `done`.
- nbits=0 edge case: required `done` in the cycle after LOAD; no strobes at all.
- Reset mid-burst: `rst` for 1 cycle during RUN. Required: all outputs 0 next cycle; after release, a new `req` on bit 1 is granted first (pointer reset to 0).
- With `SCLK_ARB_GAP_EN`, `GAP_CYCLES`=2, back-to-back requests. Required: `busy` is low for exactly 2 cycles, plus the IDLE cycle, between bursts.
